// File: rtl/ysyx_22050019_fwd_scoreboard_if.sv
// Operand-read bundle between IDU, the forwarding sources and the forwarding/hazard unit.
// The master side is the IDU/pipeline. The slave side is the forwarding scoreboard.
interface ysyx_22050019_fwd_scoreboard_if #(
    parameter int XLEN     = 64,
    parameter int NR_RPORT = 2,
    parameter int NR_SRC   = 3,
    parameter int AW       = 5
);
    logic                       id_valid;
    logic                       id_ready;
    logic [NR_RPORT-1:0]        id_ren;
    logic [NR_RPORT*AW-1:0]     id_raddr;
    logic [NR_RPORT*XLEN-1:0]   id_rf_rdata;
    logic [NR_RPORT*XLEN-1:0]   id_rdata;
    logic                       id_ld_issue;
    logic [AW-1:0]              id_waddr;
    logic [NR_SRC-1:0]          src_wen;
    logic [NR_SRC*AW-1:0]       src_waddr;
    logic [NR_SRC*XLEN-1:0]     src_wdata;
    logic [NR_SRC-1:0]          src_dok;
    logic                       wb_ld_commit;
    logic                       flush;
    logic [NR_RPORT-1:0]        fwd_hit;

    modport master (
        output id_valid, id_ren, id_raddr, id_rf_rdata, id_ld_issue, id_waddr,
               src_wen, src_waddr, src_wdata, src_dok, wb_ld_commit, flush,
        input  id_ready, id_rdata, fwd_hit
    );

    modport slave (
        input  id_valid, id_ren, id_raddr, id_rf_rdata, id_ld_issue, id_waddr,
               src_wen, src_waddr, src_wdata, src_dok, wb_ld_commit, flush,
        output id_ready, id_rdata, fwd_hit
    );
endinterface

// File: rtl/ysyx_22050019_fwd_scoreboard.sv
// Operand forwarding and load-use hazard unit: ordered source forwarding, per-register busy
// scoreboard for outstanding loads, and per-port hold buffers that survive a stall.
module ysyx_22050019_fwd_scoreboard #(
    parameter int XLEN     = 64,
    parameter int NR_RPORT = 2,
    parameter int NR_SRC   = 3,
    parameter int AW       = 5
) (
    input  logic                             clk,
    input  logic                             rst_n,
    ysyx_22050019_fwd_scoreboard_if.slave    bus
);
    localparam int NREG = 1 << AW;

    logic [NREG-1:0]     busy_q, busy_d;
    logic [NR_RPORT-1:0] hold_v_q, hold_v_d;
    logic [XLEN-1:0]     hold_d_q [NR_RPORT];
    logic [XLEN-1:0]     hold_d_d [NR_RPORT];

    logic [NR_RPORT-1:0]      res_s, hit_s, from_src_s;
    logic [XLEN-1:0]          data_s [NR_RPORT];
    logic [NR_RPORT*XLEN-1:0] rdata_s;
    logic                     ready_s, fire_s;

    // Per-port resolution: hold buffer, then youngest matching source, then scoreboard, then RF.
    always_comb begin : resolve
        logic          found;
        logic [AW-1:0] raddr;
        res_s      = {NR_RPORT{1'b1}};
        hit_s      = {NR_RPORT{1'b0}};
        from_src_s = {NR_RPORT{1'b0}};
        rdata_s    = {(NR_RPORT*XLEN){1'b0}};
        found      = 1'b0;
        raddr      = {AW{1'b0}};
        for (int p = 0; p < NR_RPORT; p++) begin
            data_s[p] = bus.id_rf_rdata[p*XLEN +: XLEN];
            raddr     = bus.id_raddr[p*AW +: AW];
            found     = 1'b0;
            if (bus.id_ren[p] && (raddr != {AW{1'b0}})) begin
                if (hold_v_q[p]) begin
                    data_s[p] = hold_d_q[p];
                    hit_s[p]  = 1'b1;
                end else begin
                    for (int i = 0; i < NR_SRC; i++) begin
                        if (!found && bus.src_wen[i] && (bus.src_waddr[i*AW +: AW] == raddr)) begin
                            found = 1'b1;
                            if (bus.src_dok[i]) begin
                                data_s[p]     = bus.src_wdata[i*XLEN +: XLEN];
                                hit_s[p]      = 1'b1;
                                from_src_s[p] = 1'b1;
                            end else begin
                                res_s[p] = 1'b0;
                            end
                        end
                    end
                    // A busy register with no live source means the load has not come back yet.
                    if (!found && busy_q[raddr]) begin
                        res_s[p] = 1'b0;
                    end else begin
                        res_s[p] = res_s[p];
                    end
                end
            end else begin
                res_s[p] = 1'b1;
            end
            rdata_s[p*XLEN +: XLEN] = data_s[p];
        end
    end

    assign ready_s      = &res_s;
    assign fire_s       = bus.id_valid & ready_s;
    assign bus.id_ready = ready_s;
    assign bus.id_rdata = rdata_s;
    assign bus.fwd_hit  = hit_s;

    // Hold buffers and scoreboard next state; a same-cycle set overrides the WB clear.
    always_comb begin
        hold_v_d = hold_v_q;
        hold_d_d = hold_d_q;
        busy_d   = busy_q;
        if (fire_s || bus.flush) begin
            hold_v_d = {NR_RPORT{1'b0}};
        end else if (bus.id_valid && !ready_s) begin
            for (int p = 0; p < NR_RPORT; p++) begin
                if (from_src_s[p]) begin
                    hold_v_d[p] = 1'b1;
                    hold_d_d[p] = data_s[p];
                end else begin
                    hold_v_d[p] = hold_v_q[p];
                end
            end
        end else begin
            hold_v_d = hold_v_q;
        end
        if (bus.src_wen[NR_SRC-1] && bus.wb_ld_commit) begin
            busy_d[bus.src_waddr[(NR_SRC-1)*AW +: AW]] = 1'b0;
        end else begin
            busy_d = busy_d;
        end
        if (fire_s && bus.id_ld_issue && (bus.id_waddr != {AW{1'b0}})) begin
            busy_d[bus.id_waddr] = 1'b1;
        end else begin
            busy_d = busy_d;
        end
        busy_d[0] = 1'b0;
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q   <= {NREG{1'b0}};
            hold_v_q <= {NR_RPORT{1'b0}};
            for (int p = 0; p < NR_RPORT; p++) begin
                hold_d_q[p] <= {XLEN{1'b0}};
            end
        end else begin
            busy_q   <= busy_d;
            hold_v_q <= hold_v_d;
            for (int p = 0; p < NR_RPORT; p++) begin
                hold_d_q[p] <= hold_d_d[p];
            end
        end
    end
endmodule

// File: tb/tb_ysyx_22050019_fwd_scoreboard.sv
// Directed bench for the forwarding scoreboard: forwarding priority, load-use stall,
// hold buffers, x0/ren masking, set-vs-clear, flush and asynchronous reset.
module tb_ysyx_22050019_fwd_scoreboard;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    ysyx_22050019_fwd_scoreboard_if #(.XLEN(64), .NR_RPORT(2), .NR_SRC(3), .AW(5)) bus ();

    ysyx_22050019_fwd_scoreboard #(.XLEN(64), .NR_RPORT(2), .NR_SRC(3), .AW(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] rd(input int p);
        return bus.id_rdata[p*64 +: 64];
    endfunction

    task automatic set_src(input int i, input logic [4:0] a, input logic [63:0] d, input logic dok);
        bus.src_wen[i]           = 1'b1;
        bus.src_waddr[i*5 +: 5]  = a;
        bus.src_wdata[i*64 +: 64] = d;
        bus.src_dok[i]           = dok;
    endtask

    task automatic set_port(input int p, input logic ren, input logic [4:0] a, input logic [63:0] rf);
        bus.id_ren[p]              = ren;
        bus.id_raddr[p*5 +: 5]     = a;
        bus.id_rf_rdata[p*64 +: 64] = rf;
    endtask

    task automatic idle();
        bus.id_valid     = 1'b0;
        bus.id_ren       = 2'b00;
        bus.id_raddr     = 10'd0;
        bus.id_rf_rdata  = 128'd0;
        bus.id_ld_issue  = 1'b0;
        bus.id_waddr     = 5'd0;
        bus.src_wen      = 3'b000;
        bus.src_waddr    = 15'd0;
        bus.src_wdata    = 192'd0;
        bus.src_dok      = 3'b000;
        bus.wb_ld_commit = 1'b0;
        bus.flush        = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_load(input logic [4:0] a);
        idle();
        bus.id_valid = 1'b1; bus.id_ld_issue = 1'b1; bus.id_waddr = a;
        #1 chk("ld_issue_ready", 64'(bus.id_ready), 64'd1);
        tick();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        idle();
        set_port(0, 1'b0, 5'd0, 64'hAAAA);
        set_port(1, 1'b0, 5'd0, 64'hBBBB);
        #2;
        chk("rst_ready", 64'(bus.id_ready), 64'd1);
        chk("rst_hit",   64'(bus.fwd_hit), 64'd0);
        chk("rst_rd0",   rd(0), 64'hAAAA);
        chk("rst_rd1",   rd(1), 64'hBBBB);
        tick();
        rst_n = 1'b1;
        tick();

        // Back-to-back ALU: youngest source wins.
        idle(); bus.id_valid = 1'b1;
        set_src(0, 5'd5, 64'h11, 1'b1); set_src(1, 5'd5, 64'h22, 1'b1);
        set_port(0, 1'b1, 5'd5, 64'h55); set_port(1, 1'b0, 5'd5, 64'hB1);
        #1;
        chk("b2b_rd0", rd(0), 64'h11);
        chk("b2b_ready", 64'(bus.id_ready), 64'd1);
        chk("b2b_hit", 64'(bus.fwd_hit), 64'd1);
        chk("b2b_rd1_ren0", rd(1), 64'hB1);
        tick();

        // x0 is never forwarded.
        idle(); bus.id_valid = 1'b1;
        set_src(0, 5'd0, 64'hFF, 1'b1); set_port(0, 1'b1, 5'd0, 64'h0);
        #1;
        chk("x0_rd0", rd(0), 64'h0);
        chk("x0_ready", 64'(bus.id_ready), 64'd1);
        chk("x0_hit", 64'(bus.fwd_hit), 64'd0);
        tick();

        // Load-use on x7.
        issue_load(5'd7);
        idle(); bus.id_valid = 1'b1;
        set_port(0, 1'b1, 5'd7, 64'h77); set_port(1, 1'b0, 5'd7, 64'hB);
        set_src(0, 5'd7, 64'h1234, 1'b0);
        #1;
        chk("lu_dok0_ready", 64'(bus.id_ready), 64'd0);
        chk("lu_dok0_hit", 64'(bus.fwd_hit), 64'd0);
        tick();
        idle(); bus.id_valid = 1'b1;
        set_port(0, 1'b1, 5'd7, 64'h77); set_port(1, 1'b0, 5'd7, 64'hB);
        #1;
        chk("lu_busy_ready", 64'(bus.id_ready), 64'd0);
        chk("lu_ren0_rd1", rd(1), 64'hB);
        tick();
        set_src(2, 5'd7, 64'hDEAD, 1'b1); bus.wb_ld_commit = 1'b1;
        #1;
        chk("lu_wb_rd0", rd(0), 64'hDEAD);
        chk("lu_wb_ready", 64'(bus.id_ready), 64'd1);
        chk("lu_wb_hit", 64'(bus.fwd_hit), 64'd1);
        tick();
        idle(); bus.id_valid = 1'b1;
        set_port(0, 1'b1, 5'd7, 64'h7777);
        #1;
        chk("lu_clr_ready", 64'(bus.id_ready), 64'd1);
        chk("lu_clr_rd0", rd(0), 64'h7777);
        tick();

        // Stall hold: port0 forwarded x3, port1 waits on x8.
        issue_load(5'd8);
        idle(); bus.id_valid = 1'b1;
        set_port(0, 1'b1, 5'd3, 64'h3); set_port(1, 1'b1, 5'd8, 64'h88);
        set_src(1, 5'd3, 64'h33, 1'b1);
        #1;
        chk("hold_st_ready", 64'(bus.id_ready), 64'd0);
        chk("hold_st_rd0", rd(0), 64'h33);
        chk("hold_st_hit", 64'(bus.fwd_hit), 64'd1);
        tick();
        idle(); bus.id_valid = 1'b1;
        set_port(0, 1'b1, 5'd3, 64'h3); set_port(1, 1'b1, 5'd8, 64'h88);
        #1;
        chk("hold_rd0", rd(0), 64'h33);
        chk("hold_hit", 64'(bus.fwd_hit), 64'd1);
        chk("hold_ready", 64'(bus.id_ready), 64'd0);
        tick();
        set_src(2, 5'd8, 64'h8888, 1'b1); bus.wb_ld_commit = 1'b1;
        #1;
        chk("hold_fire_ready", 64'(bus.id_ready), 64'd1);
        chk("hold_fire_rd1", rd(1), 64'h8888);
        chk("hold_fire_rd0", rd(0), 64'h33);
        chk("hold_fire_hit", 64'(bus.fwd_hit), 64'd3);
        tick();
        idle(); bus.id_valid = 1'b1;
        set_port(0, 1'b1, 5'd3, 64'h3333); set_port(1, 1'b1, 5'd8, 64'h88);
        #1;
        chk("hold_clr_rd0", rd(0), 64'h3333);
        chk("hold_clr_hit", 64'(bus.fwd_hit), 64'd0);
        chk("hold_clr_ready", 64'(bus.id_ready), 64'd1);
        tick();

        // Same-cycle set and clear of x9: set wins.
        issue_load(5'd9);
        idle(); bus.id_valid = 1'b1; bus.id_ld_issue = 1'b1; bus.id_waddr = 5'd9;
        set_src(2, 5'd9, 64'h99, 1'b1); bus.wb_ld_commit = 1'b1;
        #1 chk("sc_ready", 64'(bus.id_ready), 64'd1);
        tick();
        idle(); bus.id_valid = 1'b1;
        set_port(0, 1'b1, 5'd9, 64'h9); set_port(1, 1'b1, 5'd4, 64'h4);
        set_src(0, 5'd4, 64'h44, 1'b1);
        #1;
        chk("sc_busy_ready", 64'(bus.id_ready), 64'd0);
        chk("sc_rd1", rd(1), 64'h44);
        chk("sc_hit", 64'(bus.fwd_hit), 64'd2);
        tick();

        // Flush during stall drops holds, keeps busy.
        idle(); bus.id_valid = 1'b1; bus.flush = 1'b1;
        set_port(0, 1'b1, 5'd9, 64'h9); set_port(1, 1'b1, 5'd4, 64'h4);
        #1;
        chk("fl_hold_rd1", rd(1), 64'h44);
        chk("fl_hold_hit", 64'(bus.fwd_hit), 64'd2);
        tick();
        bus.flush = 1'b0;
        #1;
        chk("fl_after_rd1", rd(1), 64'h4);
        chk("fl_after_hit", 64'(bus.fwd_hit), 64'd0);
        chk("fl_busy_kept", 64'(bus.id_ready), 64'd0);

        // Asynchronous reset mid-stall.
        set_src(0, 5'd4, 64'h44, 1'b1);
        tick();
        idle(); bus.id_valid = 1'b1;
        set_port(0, 1'b1, 5'd9, 64'h9); set_port(1, 1'b1, 5'd4, 64'h4);
        #1 chk("ar_hold_rd1", rd(1), 64'h44);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_ready", 64'(bus.id_ready), 64'd1);
        chk("ar_rd1", rd(1), 64'h4);
        chk("ar_hit", 64'(bus.fwd_hit), 64'd0);
        tick();
        rst_n = 1'b1;
        #1 chk("ar_after_ready", 64'(bus.id_ready), 64'd1);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/ysyx_22050019_fwd_scoreboard.md
Name: ysyx_22050019_fwd_scoreboard

Overview:
- Parametrised operand-forwarding and hazard unit between IDU and the register file; successor of the two-source combinational forwarding mux.
- Generalises to NR_RPORT read ports, NR_SRC ordered forwarding sources and XLEN-bit data.
- Adds a per-register busy scoreboard for multi-cycle loads, a stall handshake to IDU, and per-port hold buffers so that values forwarded during a stall are not lost.

Parameters:
- XLEN, 64, data width.
- NR_RPORT, 2, number of ID read ports.
- NR_SRC, 3, forwarding sources, index 0 = youngest stage (EXU), NR_SRC-1 = WB commit.
- AW, 5, register address width; 2^AW registers; x0 is hardwired zero.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low. clk, rst_n.
- id_valid  in  1  IDU holds a valid instruction.
- id_ready  out  1  operands resolved; id_fire = id_valid & id_ready.
- id_ren  in  NR_RPORT  per-port read enable.
- id_raddr  in  NR_RPORT*AW  flattened read addresses; port p occupies [p*AW +: AW].
- id_rf_rdata  in  NR_RPORT*XLEN  raw register file read data.
- id_rdata  out  NR_RPORT*XLEN  resolved operands.
- id_ld_issue  in  1  instruction in ID writes rd from a load.
- id_waddr  in  AW  rd of the instruction in ID.
- src_wen  in  NR_SRC  source carries a register write.
- src_waddr  in  NR_SRC*AW  destination address per source.
- src_wdata  in  NR_SRC*XLEN  write data per source.
- src_dok  in  NR_SRC  src_wdata valid; 0 for a load not yet returned.
- wb_ld_commit  in  1  source NR_SRC-1 is committing a load result.
- flush  in  1  squash the instruction in ID.
- fwd_hit  out  NR_RPORT  debug: port served by hold or a source.

Behaviour:
- State:
  - busy[2^AW-1:1]: pending load writes.
  - hold_v[p], hold_d[p]: per-port hold buffers.
  - Reset clears all of them. Outputs after reset: id_ready=1, fwd_hit=0, id_rdata equals id_rf_rdata.
- Per-port resolution (combinational). A port is ignored (resolved, data=id_rf_rdata) when id_ren[p]=0 or raddr=0. Otherwise, in priority order:
  1. hold_v[p]=1: data=hold_d, resolved, hit=1.
  2. The lowest-index source i with src_wen[i] and src_waddr[i]==raddr:
     - if src_dok[i]=1: data=src_wdata[i], resolved, hit=1;
     - otherwise pending (hit=0).
  3. busy[raddr]=1: pending.
  4. Otherwise: data=id_rf_rdata, resolved.
- id_ready = AND of all ports resolved. id_ready never depends on id_valid.
- Hold capture (registered):
  - When id_valid & ~id_ready & ~flush, every port resolved via step 2 captures: hold_v<=1, hold_d<=src_wdata.
  - All hold_v clear on id_fire or flush.
  - Ports resolved by step 4 are not held, because the register file is stable during a stall.
- Scoreboard (registered):
  - Set busy[id_waddr] on id_fire & id_ld_issue & id_waddr!=0.
  - Clear busy[src_waddr[NR_SRC-1]] on src_wen[NR_SRC-1] & wb_ld_commit.
  - Same address set and cleared in one cycle: set wins (the younger load remains outstanding).
  - flush does not touch busy; only ID is squashed, and loads beyond ID always commit.
- Latency: resolution is 0-cycle combinational. Hold and busy update on the next rising edge.
- A WB commit is visible in the same cycle through source NR_SRC-1, so there is no extra stall for register-file write-then-read.
- rst_n deassertion mid-stall drops the hold buffers and the scoreboard; the pipeline is reset together with this block.

Test Plan:
- Back-to-back ALU: EXU (src0) writes x5=0x11, LSU (src1) writes x5=0x22, ID reads x5 on port0 -> id_rdata[port0]=0x11, id_ready=1, fwd_hit[0]=1.
- Load-use: load to x7 issued (busy[7]=1); next instruction reads x7 while src0 has x7 with dok=0 -> id_ready=0 until the WB commit cycle. In that cycle id_rdata=load value 0xDEAD, id_ready=1, and busy[7] clears on the edge.
- Stall hold: port0 reads x3 from src1 (dok=1, 0x33), port1 stalls on pending x8. Next cycle x3 leaves all sources -> port0 still returns 0x33 from hold. After id_fire, hold_v=0.
- x0 and ren=0: src0 writes x0=0xFF, ID reads x0 -> data equals id_rf_rdata (0) and no stall. A port with id_ren=0 and busy address -> no stall.
- Simultaneous set/clear: WB commits a load to x9 while ID fires a new load to x9 -> busy[9]=1 after the edge.
- Flush during stall: stalled with hold_v=1, assert flush -> hold_v=0 next cycle, busy unchanged. Async rst_n low mid-stall -> busy=0, hold_v=0 immediately.
